// File: rtl/vote_input_conditioner.sv
// Vote input conditioner: synchronizes and debounces three candidate buttons,
// then turns single clean presses into one-cycle vote pulses with a lockout.
`timescale 1ns/1ps
module vote_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       btn_candidate_1,
  input  logic       btn_candidate_2,
  input  logic       btn_candidate_3,
  output logic       in_candidate_1,
  output logic       in_candidate_2,
  output logic       in_candidate_3,
  output logic       vote_busy,
  output logic       vote_reject
);

  typedef enum logic {
    IDLE,
    LOCKOUT
  } state_e;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LK_MAX  = 8'(LOCKOUT_CYCLES);
  localparam logic [1:0] MODE_VOTE = 2'd1;

  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] db_q, db_d;
  logic [2:0] prev_q;
  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];

  state_e     state_q, state_d;
  logic [7:0] lock_q, lock_d;
  logic [7:0] lock_inc;
  logic [2:0] vote_q, vote_d;
  logic       busy_q, busy_d;
  logic       rej_q, rej_d;

  logic [2:0] ev;
  logic       multi;
  logic       single;

  assign raw = {btn_candidate_3, btn_candidate_2, btn_candidate_1};

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign ev     = db_q & ~prev_q;
  assign multi  = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
  assign single = (|ev) & ~multi;

  // Saturating count of cycles already spent in LOCKOUT
  assign lock_inc = (lock_q == LK_MAX) ? LK_MAX : lock_q + 8'd1;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    vote_d  = 3'b000;
    rej_d   = 1'b0;
    if (mode != MODE_VOTE) begin
      state_d = IDLE;
      lock_d  = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (single) begin
            vote_d  = ev;
            state_d = LOCKOUT;
            lock_d  = 8'd0;
          end else if (multi) begin
            rej_d   = 1'b1;
            state_d = LOCKOUT;
            lock_d  = 8'd0;
          end
        end
        LOCKOUT: begin
          lock_d = lock_inc;
          if ((lock_inc == LK_MAX) && (db_q == 3'b000)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      db_q    <= 3'b000;
      prev_q  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= 8'd0;
      end
      state_q <= IDLE;
      lock_q  <= 8'd0;
      vote_q  <= 3'b000;
      busy_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      prev_q  <= db_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q <= state_d;
      lock_q  <= lock_d;
      vote_q  <= vote_d;
      busy_q  <= busy_d;
      rej_q   <= rej_d;
    end
  end

  assign in_candidate_1 = vote_q[0];
  assign in_candidate_2 = vote_q[1];
  assign in_candidate_3 = vote_q[2];
  assign vote_busy      = busy_q;
  assign vote_reject    = rej_q;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Directed bench for vote_input_conditioner at default parameters.
`timescale 1ns/1ps
module tb_vote_input_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       b1 = 1'b0;
  logic       b2 = 1'b0;
  logic       b3 = 1'b0;
  logic       c1, c2, c3, busy, rej;
  logic [2:0] votes;
  logic [4:0] seen;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  vote_input_conditioner dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .btn_candidate_1(b1),
    .btn_candidate_2(b2),
    .btn_candidate_3(b3),
    .in_candidate_1 (c1),
    .in_candidate_2 (c2),
    .in_candidate_3 (c3),
    .vote_busy      (busy),
    .vote_reject    (rej)
  );

  assign votes = {c3, c2, c1};

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      tick(1);
      seen |= {rej, busy, votes};
    end
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_votes", 8'(votes), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_rej", 8'(rej), 8'h0);
    reset = 1'b1;
    mode  = 2'd1;
    tick(2);

    // single press held 20 cycles
    b2 = 1'b1;
    tick(6);
    chk("t1_e6", 8'(votes), 8'h0);
    tick(1);
    chk("t1_e7", 8'(votes), 8'h2);
    chk("t1_busy7", 8'(busy), 8'h1);
    tick(1);
    chk("t1_e8", 8'(votes), 8'h0);
    chk("t1_busy8", 8'(busy), 8'h1);
    tick(12);
    b2 = 1'b0;
    tick(6);
    chk("t1_busy26", 8'(busy), 8'h1);
    chk("t1_e26", 8'(votes), 8'h0);
    tick(1);
    chk("t1_busy27", 8'(busy), 8'h0);

    // glitch shorter than the debounce window
    tick(3);
    seen = '0;
    b1 = 1'b1;
    watch(3);
    b1 = 1'b0;
    watch(12);
    chk("t2_quiet", 8'(seen), 8'h0);

    // simultaneous double press
    b1 = 1'b1;
    b3 = 1'b1;
    tick(6);
    chk("t3_rej6", 8'(rej), 8'h0);
    tick(1);
    chk("t3_rej7", 8'(rej), 8'h1);
    chk("t3_votes7", 8'(votes), 8'h0);
    chk("t3_busy7", 8'(busy), 8'h1);
    tick(1);
    chk("t3_rej8", 8'(rej), 8'h0);
    tick(2);
    b1 = 1'b0;
    b3 = 1'b0;
    tick(6);
    chk("t3_busy16", 8'(busy), 8'h1);
    tick(1);
    chk("t3_busy17", 8'(busy), 8'h0);

    // press during lockout is dropped
    tick(2);
    b3 = 1'b1;
    tick(5);
    b3 = 1'b0;
    tick(2);
    chk("t4_vote3", 8'(votes), 8'h4);
    chk("t4_busy7", 8'(busy), 8'h1);
    seen = '0;
    b1 = 1'b1;
    watch(5);
    b1 = 1'b0;
    watch(6);
    chk("t4_busy18", 8'(busy), 8'h1);
    chk("t4_drop", 8'({seen[4], seen[2:0]}), 8'h0);
    tick(1);
    chk("t4_busy19", 8'(busy), 8'h0);
    b1 = 1'b1;
    tick(6);
    chk("t4_e6", 8'(votes), 8'h0);
    tick(1);
    chk("t4_vote1", 8'(votes), 8'h1);
    b1 = 1'b0;
    tick(8);
    chk("t4_idle", 8'(busy), 8'h0);

    // non-voting mode, then held button across mode change
    mode = 2'd2;
    seen = '0;
    repeat (2) begin
      b2 = 1'b1;
      watch(10);
      b2 = 1'b0;
      watch(10);
    end
    b2 = 1'b1;
    watch(10);
    mode = 2'd1;
    watch(10);
    b2 = 1'b0;
    watch(8);
    chk("t5_quiet", 8'(seen), 8'h0);
    b2 = 1'b1;
    tick(6);
    chk("t5_e6", 8'(votes), 8'h0);
    tick(1);
    chk("t5_vote2", 8'(votes), 8'h2);
    b2 = 1'b0;
    tick(8);
    chk("t5_idle", 8'(busy), 8'h0);

    // reset mid-debounce, button still held
    tick(2);
    b1 = 1'b1;
    tick(4);
    reset = 1'b0;
    seen = '0;
    watch(2);
    chk("t6_rst_quiet", 8'(seen), 8'h0);
    reset = 1'b1;
    tick(6);
    chk("t6_e6", 8'(votes), 8'h0);
    tick(1);
    chk("t6_vote1", 8'(votes), 8'h1);
    chk("t6_busy", 8'(busy), 8'h1);

    // async reset mid-lockout
    tick(2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_busy", 8'(busy), 8'h0);
    chk("t6_async_votes", 8'(votes), 8'h0);
    tick(1);
    reset = 1'b1;
    tick(6);
    chk("t6_re6", 8'(votes), 8'h0);
    tick(1);
    chk("t6_revote", 8'(votes), 8'h1);
    b1 = 1'b0;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
